bsg_xor_descramble: RTL and testbench

//  Receive end of the additive (XOR-keystream) link scrambler. Each accepted

---
 rtl/bsg_xor_scramble_pkg.sv | 27 ++
 rtl/bsg_prbs31_step.sv | 31 +++
 rtl/bsg_xor_descramble.sv | 102 ++++++++++
 tb/tb_bsg_xor_descramble.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_xor_scramble_pkg.sv
// Shared definitions for the PRBS31 additive link scrambler/descrambler pair.
// Used by both the TX scrambler and the RX descrambler (bsg_xor_descramble).
//
// Contents:
//   prbs31_width_gp   LFSR state width
//   prbs31_seed_gp    default LFSR seed (non-zero)
//   prbs31_state_t    LFSR state type
//   tap constants     feedback taps for x^31 + x^28 + 1 (state bits 0 and 3)
//   prbs31_advance1   one-bit LFSR step
package bsg_xor_scramble_pkg;

    localparam int unsigned prbs31_width_gp = 31;

    typedef logic [prbs31_width_gp-1:0] prbs31_state_t;

    localparam prbs31_state_t prbs31_seed_gp = 31'h1;

    // Fibonacci form: the bit shifted out (s[0]) is the key bit, and the new
    // top bit is s[0] ^ s[3].
    localparam int unsigned prbs31_tap_lo_gp = 0;
    localparam int unsigned prbs31_tap_hi_gp = 3;

    function automatic prbs31_state_t prbs31_advance1(input prbs31_state_t s);
        return {s[prbs31_tap_lo_gp] ^ s[prbs31_tap_hi_gp], s[prbs31_width_gp-1:1]};
    endfunction

endpackage

// File: rtl/bsg_prbs31_step.sv
// Combinational PRBS31 multi-step: advances the LFSR width_p times and
// collects the key bit produced at each step.
//
// Ports:
//   state_i      LFSR state before the block
//   keystream_o  width_p key bits; bit 0 is the first bit generated
//   state_o      LFSR state after width_p steps
module bsg_prbs31_step
    import bsg_xor_scramble_pkg::*;
#(
    parameter int unsigned width_p = 128
) (
    input  prbs31_state_t        state_i,
    output logic [width_p-1:0]   keystream_o,
    output prbs31_state_t        state_o
);

    prbs31_state_t s;

    // Unrolled serial LFSR; synthesis flattens it into an XOR network.
    always_comb begin
        s           = state_i;
        keystream_o = '0;
        for (int k = 0; k < int'(width_p); k++) begin
            keystream_o[k] = s[prbs31_tap_lo_gp];
            s              = prbs31_advance1(s);
        end
        state_o = s;
    end

endmodule

// File: rtl/bsg_xor_descramble.sv
// Receive-side additive descrambler: each accepted word is XORed with the
// next width_p bits of a PRBS31 keystream. One registered stage with a
// valid/ready input and a valid/yumi output.
//
// Optional feature: define BSG_XOR_DESCRAMBLE_BYPASS_EN to add bypass_i.
// A bypassed word passes through unscrambled and does not consume keystream;
// a bypassed sync word still reseeds the LFSR.
//
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   v_i        input word valid
//   sync_i     word is first of a frame; keystream restarts from seed_p
//   data_i     scrambled input word
//   ready_o    a word can be accepted this cycle
//   v_o        output word valid
//   data_o     descrambled output word
//   yumi_i     consumer takes data_o this cycle (only when v_o=1)
//   bypass_i   pass word through untouched (BSG_XOR_DESCRAMBLE_BYPASS_EN only)
module bsg_xor_descramble
    import bsg_xor_scramble_pkg::*;
#(
    parameter int unsigned   width_p = 128,
    parameter prbs31_state_t seed_p  = prbs31_seed_gp
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic               sync_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
`ifdef BSG_XOR_DESCRAMBLE_BYPASS_EN
    ,
    input  logic               bypass_i
`endif
);

    logic               v_q, v_d;
    logic [width_p-1:0] data_q, data_d;
    prbs31_state_t      lfsr_q, lfsr_d;

    logic               bypass;
    logic               accept;
    prbs31_state_t      step_in;
    prbs31_state_t      step_out;
    logic [width_p-1:0] keystream;

`ifdef BSG_XOR_DESCRAMBLE_BYPASS_EN
    assign bypass = bypass_i;
`else
    assign bypass = 1'b0;
`endif

    // The output register can take a new word whenever it is empty or is
    // being emptied this same cycle.
    assign ready_o = ~v_q | yumi_i;
    assign accept  = v_i & ready_o;

    // A sync word restarts the keystream, so its key block comes from the seed.
    assign step_in = sync_i ? seed_p : lfsr_q;

    bsg_prbs31_step #(
        .width_p (width_p)
    ) u_step (
        .state_i     (step_in),
        .keystream_o (keystream),
        .state_o     (step_out)
    );

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        lfsr_d = lfsr_q;
        if (accept) begin
            v_d    = 1'b1;
            data_d = bypass ? data_i : (data_i ^ keystream);
            // A bypassed word consumes no keystream, but sync still reseeds.
            lfsr_d = bypass ? step_in : step_out;
        end else if (yumi_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            lfsr_q <= seed_p;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            lfsr_q <= lfsr_d;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;

endmodule

// File: tb/tb_bsg_xor_descramble.sv
module tb_bsg_xor_descramble;
    import bsg_xor_scramble_pkg::*;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         reset_n_i;
    logic         v_i, sync_i, yumi_i;
    logic [W-1:0] data_i;
    logic         ready_o, v_o;
    logic [W-1:0] data_o;
`ifdef BSG_XOR_DESCRAMBLE_BYPASS_EN
    logic         bypass_i;
`endif

    always #5 clk = ~clk;

    bsg_xor_descramble #(
        .width_p (W),
        .seed_p  (prbs31_seed_gp)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .sync_i    (sync_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i)
`ifdef BSG_XOR_DESCRAMBLE_BYPASS_EN
        ,
        .bypass_i  (bypass_i)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Keystream of one frame as a bit sequence. From s[i](t) = k[t+i] and the
    // feedback rule, k[m] = k[m-31] ^ k[m-28]; the first 31 bits are the seed.
    bit ks[$];

    function automatic logic [W-1:0] key_at(input int pos);
        logic [W-1:0]  k;
        prbs31_state_t seed;
        int            n;
        seed = prbs31_seed_gp;
        while (ks.size() < pos + W) begin
            n = ks.size();
            if (n < 31) ks.push_back(seed[n]);
            else        ks.push_back(ks[n-31] ^ ks[n-28]);
        end
        for (int i = 0; i < W; i++) k[i] = ks[pos+i];
        return k;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output-side model: a one-entry queue of expected plaintext.
    bit           mv;
    logic [W-1:0] exp_q[$];

    task automatic do_reset();
        reset_n_i = 1'b0;
        v_i = 1'b0; sync_i = 1'b0; yumi_i = 1'b0; data_i = '0;
`ifdef BSG_XOR_DESCRAMBLE_BYPASS_EN
        bypass_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n_i = 1'b1;
        @(posedge clk);
        #1;
        mv = 1'b0;
        exp_q.delete();
    endtask

    task automatic step(input logic v, input logic s, input logic y, input logic b,
                        input logic [W-1:0] d, input logic [W-1:0] plain, output logic acc);
        v_i = v; sync_i = s; yumi_i = y; data_i = d;
`ifdef BSG_XOR_DESCRAMBLE_BYPASS_EN
        bypass_i = b;
`else
        if (b) $display("bypass requested in a build without bypass");
`endif
        #1;
        chk("ready_o", {127'b0, ready_o}, {127'b0, (!mv || y)});
        acc = v && (!mv || y);
        if (mv && y) begin
            void'(exp_q.pop_front());
            mv = 1'b0;
        end
        if (acc) begin
            exp_q.push_back(plain);
            mv = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("v_o", {127'b0, v_o}, {127'b0, mv});
        if (mv) chk("data_o", data_o, exp_q[0]);
    endtask

    // Sender: scrambles plaintext with the frame keystream, sync on word 0 and
    // every 64th word. rnd=0 gives back-to-back traffic with yumi every cycle.
    task automatic run_words(input int nwords, input bit rnd, input int byp_word);
        int           w = 0, spos = 0, pos = 0, cyc = 0;
        bit           pending = 0;
        logic         acc, s = 0, b = 0, vv, y;
        logic [W-1:0] plain = '0, scr = '0;
        while (w < nwords && cyc < nwords * 8 + 16) begin
            if (!pending) begin
                plain = {$urandom(), $urandom(), $urandom(), $urandom()};
                s     = (w % 64 == 0);
                b     = (w == byp_word);
`ifdef BSG_XOR_DESCRAMBLE_BYPASS_EN
                if (rnd && $urandom_range(0, 15) == 0) b = 1'b1;
`endif
                pos     = s ? 0 : spos;
                scr     = b ? plain : (plain ^ key_at(pos));
                pending = 1;
            end
            vv = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            y  = mv && (rnd ? ($urandom_range(0, 9) < 7) : 1'b1);
            step(vv, s, y, b, scr, plain, acc);
            if (!rnd) chk("b2b_accept", {127'b0, acc}, 128'd1);
            if (acc) begin
                if (byp_word >= 0 && w == byp_word) chk("bypass_word", data_o, scr);
                if (byp_word >= 0 && w == byp_word + 1)
                    chk("after_bypass", data_o, scr ^ key_at(byp_word * W));
                spos    = pos + (b ? 0 : W);
                w++;
                pending = 0;
            end
            cyc++;
        end
        chk("words_done", W'(w), W'(nwords));
        if (mv) step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, acc);
    endtask

    typedef struct {
        logic         v, s, y;
        logic [W-1:0] d;
        logic         rdy, ev;
        logic [W-1:0] ed;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [W-1:0] x1, x2, x3, k0, k1, k2, k3;
        logic         acc;

        x1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        x2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        x3 = {$urandom(), $urandom(), $urandom(), $urandom()};
        k0 = key_at(0); k1 = key_at(W); k2 = key_at(2 * W); k3 = key_at(3 * W);
        //        v     s     y     d    rdy   ev    ed
        tbl[0] = '{1'b1, 1'b1, 1'b1, '0, 1'b1, 1'b1, k0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, x1, 1'b0, 1'b1, k0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, x1, 1'b0, 1'b1, k0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, x1, 1'b0, 1'b1, k0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, x1, 1'b1, 1'b1, x1 ^ k1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, x2, 1'b1, 1'b1, x2 ^ k2};
        tbl[6] = '{1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b0, '0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, x3, 1'b1, 1'b1, x3 ^ k3};
        tbl[9] = '{1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b0, '0};

        do_reset();
        chk("reset_v_o", {127'b0, v_o}, '0);
        chk("reset_data_o", data_o, '0);
        chk("reset_ready_o", {127'b0, ready_o}, 128'd1);

        // Sync word, stall, drain, idle, resume: keystream blocks must follow on.
        for (int i = 0; i < 10; i++) begin
            v_i = tbl[i].v; sync_i = tbl[i].s; yumi_i = tbl[i].y; data_i = tbl[i].d;
            #1;
            chk($sformatf("tbl%0d_ready", i), {127'b0, ready_o}, {127'b0, tbl[i].rdy});
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_v", i), {127'b0, v_o}, {127'b0, tbl[i].ev});
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), data_o, tbl[i].ed);
            if (i == 0) chk("seed1_lo32", {96'b0, data_o[31:0]}, {96'b0, 32'h8000_0001});
        end

        // Reset while a word is held.
        v_i = 1'b1; sync_i = 1'b1; yumi_i = 1'b0; data_i = x2;
        @(posedge clk);
        #1;
        chk("pre_rst_v", {127'b0, v_o}, 128'd1);
        v_i = 1'b0; sync_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        chk("mid_rst_v", {127'b0, v_o}, '0);
        chk("mid_rst_data", data_o, '0);
        chk("mid_rst_ready", {127'b0, ready_o}, 128'd1);
        @(negedge clk) reset_n_i = 1'b1;
        @(posedge clk);
        #1;
        mv = 1'b0;
        exp_q.delete();
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, k0, acc);
        chk("post_rst_lo32", {96'b0, data_o[31:0]}, {96'b0, 32'h8000_0001});
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, acc);

        run_words(12, 1'b0, -1);
        run_words(1000, 1'b1, -1);

`ifdef BSG_XOR_DESCRAMBLE_BYPASS_EN
        do_reset();
        run_words(8, 1'b0, 5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
